ext_exit_ctrl: RTL and testbench



---
 rtl/ext_exit_ctrl.sv | 140 ++++++++++++++
 tb/tb_ext_exit_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_exit_ctrl.sv
// ext_exit_ctrl: MMIO console/exit device sitting on the core's store port.
// Stores to PUTCHAR_ADDR queue a character for the host sink. A store to
// EXIT_ADDR latches an exit code, waits for the console to drain plus
// DRAIN_CYCLES idle cycles, pulses {1'b1, code} on finish_arg for one cycle,
// and then halts until reset.
// Optional build macro: EXT_EXIT_TIMEOUT_EN adds a RUN-state watchdog that
// forces exit code 8'hFF after TIMEOUT_CYCLES cycles.
module ext_exit_ctrl #(
  parameter logic [31:0] PUTCHAR_ADDR   = 32'h4000_0000,
  parameter logic [31:0] EXIT_ADDR      = 32'h4000_1000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [8:0]  finish_arg,
  output logic        halted
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FINISH, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic [31:0] cnt_q, cnt_d;
  logic        rsp_q;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  logic empty, full, accept, push, pop, exit_acc, timeout;

  // Upper data bytes and byte lanes 1..3 carry nothing this device uses.
  logic unused_bits;
  assign unused_bits = ^{req_data[31:8], req_wmask[3:1]};

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A full FIFO refuses a putchar even if the sink pops this same cycle.
  assign req_ready = (state_q == S_RUN) && !((req_addr == PUTCHAR_ADDR) && full);
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_addr == PUTCHAR_ADDR) && req_wmask[0];
  assign exit_acc  = accept && (req_addr == EXIT_ADDR) && req_wmask[0];
  assign pop       = !empty && tx_ready;

  assign tx_valid   = !empty;
  assign tx_data    = mem_q[rptr_q[AW-1:0]];
  assign rsp_valid  = rsp_q;
  assign halted     = (state_q == S_HALT);
  assign finish_arg = (state_q == S_FINISH) ? {1'b1, code_q} :
                      (state_q == S_HALT)   ? {1'b0, code_q} : 9'h000;

`ifdef EXT_EXIT_TIMEOUT_EN
  logic [31:0] wd_q;

  // Watchdog: counts RUN cycles, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST)                  wd_q <= '0;
    else if (state_q == S_RUN) wd_q <= wd_q + 32'd1;
  end

  assign timeout = (state_q == S_RUN) && (wd_q == TIMEOUT_CYCLES - 32'd1);
`else
  assign timeout = 1'b0;
`endif

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= req_data[7:0];
  end

  // FIFO pointers and store acknowledge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      rsp_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      rsp_q <= accept;
    end
  end

  // Control state, latched exit code and drain counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_RUN;
      code_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; an exit store beats a simultaneous watchdog expiry.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (exit_acc) begin
          code_d  = req_data[7:0];
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else if (timeout) begin
          code_d  = 8'hFF;
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (empty) begin
          if (cnt_q == 32'(DRAIN_CYCLES)) state_d = S_FINISH;
          else                            cnt_d   = cnt_q + 32'd1;
        end
      end
      S_FINISH: state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_ext_exit_ctrl.sv
// Bench for ext_exit_ctrl: a default instance (DRAIN_CYCLES=16) plus a
// DRAIN_CYCLES=0 / TIMEOUT_CYCLES=100 instance. Console characters are
// checked against a queue of expected bytes filled as stores are accepted.
module tb_ext_exit_ctrl;

  localparam logic [31:0] PUT  = 32'h4000_0000;
  localparam logic [31:0] EXIT = 32'h4000_1000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0, req_data = '0;
  logic [3:0]  req_wmask = '0;
  logic        rsp_valid, tx_valid, tx_ready = 1'b0, halted;
  logic [7:0]  tx_data;
  logic [8:0]  finish_arg;

  logic        b_req_valid = 1'b0, b_req_ready;
  logic [31:0] b_req_addr = '0, b_req_data = '0;
  logic [3:0]  b_req_wmask = '0;
  logic        b_rsp_valid, b_tx_valid, b_tx_ready = 1'b1, b_halted;
  logic [7:0]  b_tx_data;
  logic [8:0]  b_finish_arg;

  int tests = 0;
  int fails = 0;
  logic [7:0] sbq[$];

  always #5 CLK = ~CLK;

  ext_exit_ctrl dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .finish_arg(finish_arg), .halted(halted)
  );

  ext_exit_ctrl #(.DRAIN_CYCLES(0), .TIMEOUT_CYCLES(32'd100)) dut0 (
    .CLK(CLK), .RST(RST), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .req_data(b_req_data), .req_wmask(b_req_wmask),
    .rsp_valid(b_rsp_valid), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
    .tx_ready(b_tx_ready), .finish_arg(b_finish_arg), .halted(b_halted)
  );

  // Every character handed to the sink must be the oldest expected byte.
  always @(negedge CLK) begin
    #2;
    if (!RST && tx_valid && tx_ready) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected got %02h with nothing expected", tx_data);
      end else begin
        logic [7:0] e;
        e = sbq.pop_front();
        if (tx_data !== e) begin
          fails++;
          $display("FAIL tx_order got %02h exp %02h", tx_data, e);
        end
      end
    end
  end

  // Drive a single-cycle store on the default instance; call in the low phase.
  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic exp_rdy, input string nm);
    req_valid = 1'b1; req_addr = a; req_data = d; req_wmask = m;
    #1;
    tests++;
    if (req_ready !== exp_rdy) begin
      fails++;
      $display("FAIL %s req_ready got %b exp %b", nm, req_ready, exp_rdy);
    end
    if (exp_rdy && a == PUT && m[0]) sbq.push_back(d[7:0]);
    @(negedge CLK);
    req_valid = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== exp_rdy) begin
      fails++;
      $display("FAIL %s rsp_valid got %b exp %b", nm, rsp_valid, exp_rdy);
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    sbq.delete();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    tests++;
    if ({rsp_valid, tx_valid, halted, finish_arg} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs got rsp=%b tx=%b halt=%b fin=%h exp all 0",
               rsp_valid, tx_valid, halted, finish_arg);
    end
    tests++;
    if (req_ready !== 1'b1 || b_finish_arg !== 9'h000) begin
      fails++;
      $display("FAIL reset_ready got rdy=%b b_fin=%h exp 1/000", req_ready, b_finish_arg);
    end
    RST = 1'b0;
    sbq.delete();
  endtask

  task automatic test_putchar();
    @(negedge CLK);
    tx_ready = 1'b1;
    store(PUT, 32'h0000_0041, 4'h1, 1'b1, "putchar");
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41 || finish_arg !== 9'h000) begin
      fails++;
      $display("FAIL putchar_tx got v=%b d=%02h fin=%h exp 1/41/000", tx_valid, tx_data, finish_arg);
    end
    @(negedge CLK);
    #1;
    tests++;
    if (tx_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL putchar_pulse got tx_valid=%b rsp=%b exp 0/0", tx_valid, rsp_valid);
    end
  endtask

  task automatic test_fifo_full();
    bit done;
    @(negedge CLK);
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(PUT, 32'h50 + i, 4'h1, 1'b1, "fill");
    req_valid = 1'b1; req_addr = PUT; req_data = 32'h54; req_wmask = 4'h1;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      fails++; $display("FAIL full_block got %b exp 0", req_ready);
    end
    @(negedge CLK);
    tx_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      fails++; $display("FAIL full_block_with_pop got %b exp 0", req_ready);
    end
    @(negedge CLK);
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL after_pop_ready got %b exp 1", req_ready);
    end
    sbq.push_back(8'h54);
    @(negedge CLK);
    req_valid = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge CLK);
      #3;
      if (sbq.size() == 0 && !tx_valid) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++; $display("FAIL fifo_drain got %0d left exp 0", sbq.size());
    end
  endtask

  task automatic test_drain();
    int k;
    bit seen;
    @(negedge CLK);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(PUT, 32'h61 + i, 4'h1, 1'b1, "queue");
    store(EXIT, 32'h0, 4'h1, 1'b1, "exit");
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1;
      tests++;
      if (req_ready !== 1'b0 || finish_arg !== 9'h000 || tx_valid !== 1'b1) begin
        fails++;
        $display("FAIL drain_hold got rdy=%b fin=%h tx=%b exp 0/000/1", req_ready, finish_arg, tx_valid);
      end
    end
    tx_ready = 1'b1;
    seen = 1'b0;
    k = 0;
    while (k < 60 && !seen) begin
      @(negedge CLK);
      #1;
      k++;
      if (finish_arg[8]) seen = 1'b1;
    end
    tests++;
    if (!seen || k != 20 || finish_arg !== 9'h100) begin
      fails++;
      $display("FAIL drain_finish got k=%0d fin=%h exp k=20 fin=100", k, finish_arg);
    end
    @(negedge CLK);
    #1;
    tests++;
    if (finish_arg !== 9'h000 || halted !== 1'b1) begin
      fails++;
      $display("FAIL halt_state got fin=%h halted=%b exp 000/1", finish_arg, halted);
    end
  endtask

  task automatic test_drain_zero();
    apply_reset();
    b_req_valid = 1'b1; b_req_addr = EXIT; b_req_data = 32'h2A; b_req_wmask = 4'h1;
    #1;
    tests++;
    if (b_req_ready !== 1'b1) begin
      fails++; $display("FAIL z_ready got %b exp 1", b_req_ready);
    end
    @(negedge CLK);
    b_req_valid = 1'b0;
    #1;
    tests++;
    if (b_rsp_valid !== 1'b1 || b_finish_arg !== 9'h000) begin
      fails++; $display("FAIL z_ack got rsp=%b fin=%h exp 1/000", b_rsp_valid, b_finish_arg);
    end
    @(negedge CLK);
    #1;
    tests++;
    if (b_finish_arg !== 9'h12A) begin
      fails++; $display("FAIL z_finish got %h exp 12a", b_finish_arg);
    end
    @(negedge CLK);
    #1;
    tests++;
    if (b_finish_arg !== 9'h02A || b_halted !== 1'b1) begin
      fails++; $display("FAIL z_halt got fin=%h halted=%b exp 02a/1", b_finish_arg, b_halted);
    end
    b_req_valid = 1'b1; b_req_addr = PUT; b_req_data = 32'h31;
    #1;
    tests++;
    if (b_req_ready !== 1'b0 || b_tx_valid !== 1'b0) begin
      fails++; $display("FAIL z_blocked got rdy=%b tx=%b exp 0/0", b_req_ready, b_tx_valid);
    end
    b_req_valid = 1'b0;
  endtask

  task automatic test_unmapped_and_reset();
    int nfin;
    @(negedge CLK);
    tx_ready = 1'b0;
    store(EXIT, 32'h55, 4'h2, 1'b1, "exit_mask2");
    tests++;
    if (finish_arg !== 9'h000 || req_ready !== 1'b1) begin
      fails++; $display("FAIL mask2_nochange got fin=%h rdy=%b exp 000/1", finish_arg, req_ready);
    end
    store(32'h4000_2000, 32'h77, 4'hF, 1'b1, "unmapped");
    store(PUT, 32'h33, 4'h2, 1'b1, "put_mask2");
    tests++;
    if (tx_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL unmapped_nochange got tx=%b rdy=%b exp 0/1", tx_valid, req_ready);
    end
    store(PUT, 32'h66, 4'h1, 1'b1, "put_pre");
    store(EXIT, 32'h09, 4'h1, 1'b1, "exit_pre");
    tests++;
    if (req_ready !== 1'b0) begin
      fails++; $display("FAIL in_drain got rdy=%b exp 0", req_ready);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    sbq.delete();
    tx_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b1 || tx_valid !== 1'b0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got rdy=%b tx=%b halted=%b exp 1/0/0", req_ready, tx_valid, halted);
    end
    nfin = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      #1;
      if (finish_arg !== 9'h000) nfin++;
    end
    tests++;
    if (nfin != 0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL no_finish got nfin=%0d rdy=%b exp 0/1", nfin, req_ready);
    end
  endtask

`ifdef EXT_EXIT_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    bit seen;
    apply_reset();
    seen = 1'b0;
    k = 0;
    while (k < 300 && !seen) begin
      @(negedge CLK);
      #1;
      k++;
      if (b_finish_arg[8]) seen = 1'b1;
    end
    tests++;
    if (!seen || b_finish_arg !== 9'h1FF || k < 100) begin
      fails++; $display("FAIL timeout got fin=%h k=%0d exp 1ff k>=100", b_finish_arg, k);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_putchar();
    test_fifo_full();
    test_drain();
    test_drain_zero();
    test_unmapped_and_reset();
`ifdef EXT_EXIT_TIMEOUT_EN
    test_timeout();
`endif
    @(negedge CLK);
    #3;
    tests++;
    if (sbq.size() != 0) begin
      fails++; $display("FAIL scoreboard_left got %0d exp 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
